q_mult: RTL and testbench



---
 rtl/q_mult.sv | 138 +++++++++++++
 tb/tb_q_mult.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/q_mult.sv
// -----------------------------------------------------------------------------
// q_mult -- two-stage pipelined sign-magnitude fixed-point multiplier.
//
// Operands and result share one format: bit N-1 is the sign and bits N-2:0
// are the magnitude with Q fractional bits. The value is
// (-1)^sign * magnitude / 2^Q.
// The product magnitude is truncated toward zero. overflow flags a product
// magnitude that does not fit in N-1 bits.
// The pipeline accepts one operation per cycle and applies no backpressure.
//
// Optional build macro:
//   QMULT_SATURATE_EN - when this macro is defined, an overflowing magnitude
//                       saturates to all ones. When it is undefined, the
//                       magnitude is the truncated slice.
//
// Parameters:
//   N  total word width including the sign bit (N >= 2)
//   Q  fractional bits (0 <= Q <= N-1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset; clears every register
//   in_valid   a/b are valid this cycle
//   a, b       operands (sign-magnitude, N bits)
//   out_valid  q_result/overflow are valid (2 cycles after input)
//   q_result   product, same format as the operands
//   overflow   product magnitude did not fit in N-1 bits
//
// The outputs hold their last value while out_valid is low.
// -----------------------------------------------------------------------------
module q_mult #(
  parameter int N = 4,
  parameter int Q = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  output logic [N-1:0] q_result,
  output logic         overflow
);

  // Magnitude width.
  localparam int M = N - 1;

  // Stage 1 operand registers.
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic         v1_q, v1_d;

  // Stage 2 result registers.
  logic [N-1:0] res_q, res_d;
  logic         ovf_q, ovf_d;
  logic         vo_q, vo_d;

  // Datapath between the two stages.
  logic [2*M-1:0] prod_s;
  logic [2*M-1:0] prod_hi_s;
  logic [M-1:0]   mag_trunc_s;
  logic [M-1:0]   mag_s;
  logic           ovf_s;
  logic           sign_s;

  // Stage 1 next state: capture the operands only when they are valid.
  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    v1_d = in_valid;
    if (in_valid) begin
      a_d = a;
      b_d = b;
    end else begin
      a_d = a_q;
      b_d = b_q;
    end
  end

  // Magnitude multiply, Q-aligned slice, overflow detection and sign resolution.
  always_comb begin
    prod_s      = {{M{1'b0}}, a_q[M-1:0]} * {{M{1'b0}}, b_q[M-1:0]};
    // Bits above Q+M-1 cannot be represented. When Q == M, the shift clears
    // everything, so overflow is never raised in that case.
    prod_hi_s   = prod_s >> (Q + M);
    ovf_s       = |prod_hi_s;
    mag_trunc_s = prod_s[Q+M-1:Q];
`ifdef QMULT_SATURATE_EN
    if (ovf_s) begin
      mag_s = {M{1'b1}};
    end else begin
      mag_s = mag_trunc_s;
    end
`else
    mag_s = mag_trunc_s;
`endif
    // A zero magnitude always gets a positive sign, so negative zero is never produced.
    sign_s = (a_q[N-1] ^ b_q[N-1]) & (|mag_s);
  end

  // Stage 2 next state: load the result on a valid stage-1 slot, otherwise hold.
  always_comb begin
    res_d = res_q;
    ovf_d = ovf_q;
    vo_d  = v1_q;
    if (v1_q) begin
      res_d = {sign_s, mag_s};
      ovf_d = ovf_s;
    end else begin
      res_d = res_q;
      ovf_d = ovf_q;
    end
  end

  // Pipeline registers with synchronous active-low reset; reset drops in-flight work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      v1_q  <= 1'b0;
      res_q <= '0;
      ovf_q <= 1'b0;
      vo_q  <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      v1_q  <= v1_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
      vo_q  <= vo_d;
    end
  end

  assign out_valid = vo_q;
  assign q_result  = res_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_q_mult.sv
module tb_q_mult;

  localparam int N = 4;
  localparam int Q = 2;
  localparam int M = N - 1;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic [N-1:0] q_result;
  logic         overflow;

  int checks;
  int failures;

  q_mult #(.N(N), .Q(Q)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .q_result (q_result),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic         ovf;
  } vec_t;

  typedef struct {
    int           due;
    logic [N-1:0] q;
    logic         ovf;
  } exp_t;

  exp_t         sb[$];
  int           step_n;
  logic [N-1:0] last_q;
  logic         last_ovf;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference model: real-number semantics using integer arithmetic.
  function automatic void model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                output logic [N-1:0] r, output logic o);
    int ma, mb, prod, scaled, mag, lim;
    logic s;
    ma     = int'(av[N-2:0]);
    mb     = int'(bv[N-2:0]);
    prod   = ma * mb;
    scaled = prod / (1 << Q);          // truncate toward zero
    lim    = 1 << M;
    o      = (scaled >= lim);
`ifdef QMULT_SATURATE_EN
    mag = o ? (lim - 1) : scaled;
`else
    mag = scaled % lim;
`endif
    s = (mag != 0) ? (av[N-1] ^ bv[N-1]) : 1'b0;
    r = {s, mag[M-1:0]};
  endfunction

  // One scoreboard cycle: check the outputs at this negedge, then drive the next edge.
  task automatic step(input logic v, input logic [N-1:0] av, input logic [N-1:0] bv,
                      input logic rn);
    logic         exp_v;
    logic [N-1:0] rq;
    logic         ro;
    @(negedge clk);
    exp_v = (sb.size() > 0) && (sb[0].due == step_n);
    check("sb_out_valid", {31'd0, out_valid}, {31'd0, exp_v});
    if (exp_v) begin
      check("sb_q_result", {28'd0, q_result}, {28'd0, sb[0].q});
      check("sb_overflow", {31'd0, overflow}, {31'd0, sb[0].ovf});
      last_q   = sb[0].q;
      last_ovf = sb[0].ovf;
      void'(sb.pop_front());
    end else begin
      check("sb_hold_q", {28'd0, q_result}, {28'd0, last_q});
      check("sb_hold_ovf", {31'd0, overflow}, {31'd0, last_ovf});
    end
    rst_n    = rn;
    in_valid = v;
    a        = av;
    b        = bv;
    if (!rn) begin
      sb.delete();
      last_q   = '0;
      last_ovf = 1'b0;
    end else if (v) begin
      model(av, bv, rq, ro);
      sb.push_back('{due: step_n + 2, q: rq, ovf: ro});
    end
    step_n++;
  endtask

  vec_t tbl[8];

  initial begin
    logic [N-1:0] hold_q;
    logic [7:0]   idx;
    logic [N-1:0] ra, rb;
    int           cnt;
    checks   = 0;
    failures = 0;
    step_n   = 0;
    last_q   = '0;
    last_ovf = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 4'b0000;
    b        = 4'b0000;

    tbl[0] = '{4'b0101, 4'b0010, 4'b0010, 1'b0};
    tbl[1] = '{4'b1100, 4'b0110, 4'b1110, 1'b0};
    tbl[2] = '{4'b1011, 4'b1011, 4'b0010, 1'b0};
    tbl[3] = '{4'b1000, 4'b0101, 4'b0000, 1'b0};
    tbl[4] = '{4'b1001, 4'b0001, 4'b0000, 1'b0};
`ifdef QMULT_SATURATE_EN
    tbl[5] = '{4'b0110, 4'b0110, 4'b0111, 1'b1};
    tbl[6] = '{4'b0111, 4'b0111, 4'b0111, 1'b1};
    tbl[7] = '{4'b1111, 4'b0111, 4'b1111, 1'b1};
`else
    tbl[5] = '{4'b0110, 4'b0110, 4'b0001, 1'b1};
    tbl[6] = '{4'b0111, 4'b0111, 4'b0100, 1'b1};
    tbl[7] = '{4'b1111, 4'b0111, 4'b1100, 1'b1};
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_q_result", {28'd0, q_result}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;

    // Directed vectors: latency of two edges, then hold while idle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a        = tbl[i].a;
      b        = tbl[i].b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("tbl_not_yet_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      check("tbl_out_valid", {31'd0, out_valid}, 32'd1);
      check("tbl_q_result", {28'd0, q_result}, {28'd0, tbl[i].q});
      check("tbl_overflow", {31'd0, overflow}, {31'd0, tbl[i].ovf});
      @(negedge clk);
      check("tbl_idle_valid", {31'd0, out_valid}, 32'd0);
      check("tbl_idle_hold", {28'd0, q_result}, {28'd0, tbl[i].q});
    end

    // Reset and in_valid asserted at the same edge: the input is dropped.
    @(negedge clk);
    hold_q   = 4'b0101;
    a        = hold_q;
    b        = 4'b0010;
    in_valid = 1'b1;
    rst_n    = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    check("rst_win_q", {28'd0, q_result}, 32'd0);
    @(negedge clk);
    check("rst_win_no_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("rst_win_no_valid2", {31'd0, out_valid}, 32'd0);

    // Scoreboard phase: start from a clean reset.
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);

    // Full 256-pair sweep with random idle gaps and a reset pulse mid-stream.
    cnt = 0;
    while (cnt < 256) begin
      if (cnt == 128) begin
        for (int r = 0; r < 3; r++) begin
          ra = 4'($urandom_range(0, 15));
          rb = 4'($urandom_range(0, 15));
          step(1'b1, ra, rb, 1'b0);
        end
      end
      if ($urandom_range(0, 4) == 0) begin
        step(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
      end else begin
        idx = 8'(cnt);
        step(1'b1, idx[7:4], idx[3:0], 1'b1);
        cnt++;
      end
    end

    // Back-to-back random operands.
    for (int i = 0; i < 200; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      step(1'b1, ra, rb, 1'b1);
    end

    // Drain the pipeline.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'b0000, 4'b0000, 1'b1);
    end
    check("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
